// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout: keeps plotted 3-bit pixels in a 160x120 framebuffer and scans them out as 640x480@60 VGA, 4x4 per pixel.
// Latency: a scan position reaches the VGA pins 2 pixel ticks after the counters hold it; a plot lands on its own clk edge.
// Backpressure: none; plot is accepted every clk and coordinates outside the framebuffer are dropped.
module vga_frame_scanout #(
   parameter int FB_W   = 160,
   parameter int FB_H   = 120,
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   input  logic       plot,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [9:0] VGA_R,
   output logic [9:0] VGA_G,
   output logic [9:0] VGA_B,
   output logic       frame_start
);

   localparam int         FB_SIZE  = FB_W * FB_H;
   localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
   localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [7:0] FB_W_L   = 8'(FB_W);
   localparam logic [6:0] FB_H_L   = 7'(FB_H);

   logic        pix_en;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [14:0] rd_addr;
   logic [6:0]  rd_row;
   logic [7:0]  rd_col;
   logic        visible;
   logic        hs_raw;
   logic        vs_raw;
   logic        origin;
   logic [2:0]  fb_mem [0:FB_SIZE-1];
   logic [2:0]  rd_data;
   logic        vis_d1;
   logic        hs_d1;
   logic        vs_d1;
   logic        origin_d1;

   // Pixel-tick enable: toggles every clk, giving the 25 MHz pixel rate and the VGA clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pix_en <= 1'b0;
      else       pix_en <= ~pix_en;
   end

   assign VGA_CLK    = pix_en;
   assign VGA_SYNC_N = 1'b0;

   // Write side: y*160 + x built from two shifts; out-of-range coordinates never reach the RAM.
   assign wr_addr = {1'b0, y, 7'd0} + {3'b000, y, 5'd0} + {7'd0, x};
   assign wr_en   = plot && (x < FB_W_L) && (y < FB_H_L);

   // Framebuffer write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) fb_mem[wr_addr] <= colour;
   end

   // Raster counters: h wraps at end of line, v advances on each h wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // Region decode on the live counters.
   assign visible = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
   assign hs_raw  = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
   assign vs_raw  = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
   assign origin  = (h_cnt == 10'd0) && (v_cnt == 10'd0);

   // Read address drops the 2 replication bits of each counter; parked at 0 outside the picture
   // so blanking rows past the framebuffer never index beyond it.
   assign rd_row  = v_cnt[8:2];
   assign rd_col  = h_cnt[9:2];
   assign rd_addr = visible ? ({1'b0, rd_row, 7'd0} + {3'b000, rd_row, 5'd0} + {7'd0, rd_col})
                            : 15'd0;

   // Registered read port, read-before-write on a same-address collision.
   // No reset here so it maps onto the RAM output register; the colour mux masks it.
   always_ff @(posedge clk) begin
      if (pix_en) rd_data <= fb_mem[rd_addr];
   end

   // Stage 1: region flags travel alongside the RAM read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vis_d1    <= 1'b0;
         hs_d1     <= 1'b1;
         vs_d1     <= 1'b1;
         origin_d1 <= 1'b0;
      end else if (pix_en) begin
         vis_d1    <= visible;
         hs_d1     <= hs_raw;
         vs_d1     <= vs_raw;
         origin_d1 <= origin;
      end
   end

   // Stage 2: registered VGA pins, colour forced to black outside the visible region.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else if (pix_en) begin
         VGA_HS      <= hs_d1;
         VGA_VS      <= vs_d1;
         VGA_BLANK_N <= vis_d1;
         VGA_R       <= vis_d1 ? {10{rd_data[2]}} : 10'd0;
         VGA_G       <= vis_d1 ? {10{rd_data[1]}} : 10'd0;
         VGA_B       <= vis_d1 ? {10{rd_data[0]}} : 10'd0;
      end
   end

   // Frame marker: high for the single clk in which the pins first show pixel (0,0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) frame_start <= 1'b0;
      else       frame_start <= pix_en & origin_d1;
   end

endmodule
